rand_word_buffer: RTL and testbench
===================================

// Module: rand_word_buffer
// PURPOSE
//  Downstream consumer of the 16-bit LFSR/CASR random word generator. Samples its free-running output,
//  discards a warm-up window after reset, and buffers fresh words in a small FIFO.
//  Serves them to masking/shuffling logic in the ML-KEM core through a pop handshake.
//  Each word is delivered at most once; the sampler never stalls the generator.
// PARAMETERS
//  DEPTH_LOG   3    log2 of FIFO depth (default 8 entries of 16 bits)
//  WARMUP      32   rand_in samples discarded after reset release (1..255)
//  RCT_CUTOFF  4    consecutive identical samples that trip the health test (2..15)
// PORTS
//  clk        in   1             system clock, all logic on rising edge
//  rst        in   1             asynchronous, active-high reset
//  rand_in    in   16            free-running random word, new value every cycle
//  rd_req     in   1             consumer pops head word this cycle
//  rd_data    out  16            FIFO head word (show-ahead), valid when rd_valid=1
//  rd_valid   out  1             FIFO non-empty and block in RUN
//  fill_cnt   out  DEPTH_LOG+1   words currently stored (0..2^DEPTH_LOG)
//  ready      out  1             warm-up finished (RUN state)
//  health_fail out 1             sticky repetition-count failure flag
// BEHAVIOUR
//  - Reset (async, any time incl. mid-transfer): state=WARM, pointers/count=0, warm-up counter=0.
//    rd_valid=0, rd_data=16'h0000, fill_cnt=0, ready=0, health_fail=0. FIFO contents not cleared.
//  - FSM states: WARM -> RUN -> FAIL.
//    WARM: counts WARMUP rising edges after reset release, no writes. Then -> RUN, ready=1 from next cycle.
//    RUN: on every edge where FIFO not full, rand_in is written at wr_ptr.
//      The first write happens on the edge after the WARM->RUN transition.
//      When full, samples are dropped (never overwrite).
//    FAIL: entered only with RAND_HEALTH_EN. Absorbing until reset.
//      Flushes FIFO (count=0), rd_valid=0, ready=0, no writes.
//  - Read: pop occurs when rd_req && rd_valid on a rising edge; rd_req while rd_valid=0 is ignored.
//    rd_data is the registered head word and updates to the next entry on the edge after the pop.
//  - Latency: write -> rd_valid high 1 cycle later (registered head). Empty FIFO refills at 1 word/cycle.
//  - Simultaneous push and pop: allowed in every fill state.
//    Count is unchanged, including full (pop frees slot, push fills it same edge).
//  - Pointers: DEPTH_LOG bits, wrap modulo 2^DEPTH_LOG.
//    fill_cnt is a separate DEPTH_LOG+1 bit counter (full = 2^DEPTH_LOG, empty = 0).
//  - Words leave the block in exact write order; no word is duplicated.
// CONFIGURATION
//  RAND_HEALTH_EN defined:
//    - Repetition-count test on rand_in, active in WARM and RUN.
//    - Counter resets to 1 when rand_in differs from the previous sample and increments when equal.
//    - On reaching RCT_CUTOFF: health_fail=1 next edge, state=FAIL.
//    - rd_valid drops that same edge.
//  RAND_HEALTH_EN undefined:
//    - No comparator/counter logic is built. health_fail tied 0. FSM never enters FAIL.
// TESTING
//  1 Warm-up: rst 1->0, rand_in incrementing; rd_valid=0 for 32 edges.
//    First stored word equals the sample on edge 33; ready=1 after edge 32.
//  2 Fill/full: rd_req=0 for 50 cycles after warm-up -> fill_cnt=8.
//    rd_valid=1 and later samples dropped; pop 8 -> exact 8 consecutive words in order, then rd_valid=0.
//  3 Concurrent: rd_req=1 held at full (fill_cnt=8) for 20 cycles.
//    fill_cnt stays 8 and each popped word is a distinct, in-order sample.
//  4 Wrap: alternate 5 pops / 3 idle for 100 cycles.
//    Scoreboard model matches every rd_data; no loss/duplication across pointer wrap.
//  5 Health (RAND_HEALTH_EN): rand_in=16'hA5A5 held 4 cycles in RUN.
//    health_fail=1, rd_valid=0, fill_cnt=0, and both stay set until rst; without macro health_fail stays 0.
//  6 Reset mid-run: assert rst asynchronously with fill_cnt=5.
//    Outputs zero immediately without clock; after release warm-up repeats as in 1.

Source files
------------

// File: rtl/rand_word_buffer.sv
// Samples a free-running random word, drops a warm-up window, buffers fresh words in a show-ahead FIFO.
// Latency: a word is written on the edge it is sampled and appears on rd_data after that same edge.
// Backpressure: the generator is never stalled; samples arriving while full are dropped. Optional RAND_HEALTH_EN.
module rand_word_buffer #(
    parameter int DEPTH_LOG  = 3,
    parameter int WARMUP     = 32,
    parameter int RCT_CUTOFF = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          rand_in,
    input  logic                 rd_req,
    output logic [15:0]          rd_data,
    output logic                 rd_valid,
    output logic [DEPTH_LOG:0]   fill_cnt,
    output logic                 ready,
    output logic                 health_fail
);

    localparam int                 DEPTH     = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] FULL_CNT  = (DEPTH_LOG + 1)'(DEPTH);
    localparam logic [7:0]         WARM_LAST = 8'(WARMUP - 1);

    localparam logic [1:0] ST_WARM = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FAIL = 2'd2;

    if (DEPTH_LOG < 1 || WARMUP < 1 || WARMUP > 255 || RCT_CUTOFF < 2 || RCT_CUTOFF > 15) begin : g_param_check
        $error("rand_word_buffer: parameter out of range");
    end

    logic [1:0]           state;
    logic [7:0]           warm_cnt;
    logic [15:0]          mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr_nxt;
    logic [DEPTH_LOG:0]   count;
    logic [15:0]          head_q;
    logic [15:0]          head_nxt;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 trip;

    assign full     = (count == FULL_CNT);
    assign rd_valid = (state == ST_RUN) && (count != '0);
    assign pop      = rd_req && rd_valid;
    // A pop at full frees the slot the same-edge push fills, so count holds.
    assign push     = (state == ST_RUN) && (!full || pop);

    assign rd_data  = head_q;
    assign fill_cnt = count;
    assign ready    = (state == ST_RUN);

`ifdef RAND_HEALTH_EN
    logic [15:0] prev_q;
    logic [3:0]  rct_q;
    logic [3:0]  rct_nxt;
    logic        fail_q;

    always_comb begin
        rct_nxt = 4'd1;
        if (rand_in == prev_q) begin
            rct_nxt = 4'(rct_q + 4'd1);
        end
    end

    assign trip        = (state != ST_FAIL) && (rct_nxt >= 4'(RCT_CUTOFF));
    assign health_fail = fail_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 16'h0000;
            rct_q  <= 4'd0;
            fail_q <= 1'b0;
        end else begin
            prev_q <= rand_in;
            if (state != ST_FAIL) begin
                rct_q <= rct_nxt;
            end
            if (trip) begin
                fail_q <= 1'b1;
            end
        end
    end
`else
    assign trip        = 1'b0;
    assign health_fail = 1'b0;
`endif

    // Next head: the word being written bypasses the RAM when it becomes the head.
    always_comb begin
        rd_ptr_nxt = rd_ptr;
        if (pop) begin
            rd_ptr_nxt = rd_ptr + 1'b1;
        end
        head_nxt = mem[rd_ptr_nxt];
        if (push && (rd_ptr_nxt == wr_ptr)) begin
            head_nxt = rand_in;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !trip) begin
            mem[wr_ptr] <= rand_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_WARM;
            warm_cnt <= 8'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            head_q   <= 16'h0000;
        end else if (trip) begin
            state  <= ST_FAIL;
            count  <= '0;
            head_q <= 16'h0000;
        end else begin
            case (state)
                ST_WARM: begin
                    if (warm_cnt == WARM_LAST) begin
                        state <= ST_RUN;
                    end else begin
                        warm_cnt <= warm_cnt + 8'd1;
                    end
                end
                ST_RUN: begin
                    if (push) begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                    if (pop) begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                    count  <= count + {{DEPTH_LOG{1'b0}}, push} - {{DEPTH_LOG{1'b0}}, pop};
                    head_q <= head_nxt;
                end
                ST_FAIL: begin
                    count  <= '0;
                    head_q <= 16'h0000;
                end
                default: begin
                    state <= ST_FAIL;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rand_word_buffer.sv
// Random-stimulus bench for rand_word_buffer against a queue-based reference model.
module tb_rand_word_buffer;

    localparam int DEPTH_LOG  = 3;
    localparam int DEPTH      = 1 << DEPTH_LOG;
    localparam int WARMUP     = 32;
    localparam int RCT_CUTOFF = 4;

    logic                 clk;
    logic                 rst;
    logic [15:0]          rand_in;
    logic                 rd_req;
    logic [15:0]          rd_data;
    logic                 rd_valid;
    logic [DEPTH_LOG:0]   fill_cnt;
    logic                 ready;
    logic                 health_fail;

    rand_word_buffer #(
        .DEPTH_LOG (DEPTH_LOG),
        .WARMUP    (WARMUP),
        .RCT_CUTOFF(RCT_CUTOFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rand_in    (rand_in),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .fill_cnt   (fill_cnt),
        .ready      (ready),
        .health_fail(health_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    int          edges;
    logic [15:0] q[$];
    bit          mfail;
    logic [15:0] mprev;
    int          mrct;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        edges = 0;
        q.delete();
        mfail = 1'b0;
        mprev = 16'h0000;
        mrct  = 0;
    endtask

    // One rising edge of the reference: ready after WARMUP edges, push whenever room (or popping).
    task automatic model_edge();
        bit rdy;
        bit pop;
        bit push;
        if (rst) begin
            model_reset();
            return;
        end
        rdy  = !mfail && (edges >= WARMUP);
        pop  = rd_req && rdy && (q.size() > 0);
        push = rdy && ((q.size() < DEPTH) || pop);
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(rand_in);
`ifdef RAND_HEALTH_EN
        if (!mfail) begin
            mrct = (rand_in == mprev) ? mrct + 1 : 1;
            if (mrct >= RCT_CUTOFF) begin
                mfail = 1'b1;
                q.delete();
            end
        end
`endif
        mprev = rand_in;
        edges++;
    endtask

    task automatic compare_all();
        bit rdy;
        rdy = !mfail && (edges >= WARMUP);
        chk("ready", ready, rdy);
        chk("rd_valid", rd_valid, rdy && (q.size() > 0));
        chk("fill_cnt", fill_cnt, q.size());
        chk("health_fail", health_fail, mfail);
        if (rdy && q.size() > 0) chk("rd_data", rd_data, q[0]);
    endtask

    task automatic step(input logic req, input logic [15:0] din);
        rd_req  = req;
        rand_in = din;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_fill_cnt"}, fill_cnt, 0);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_health"}, health_fail, 0);
    endtask

    // Warm-up with incrementing input; word sampled on edge WARMUP+1 must be first out.
    task automatic warmup_run(input logic [15:0] base);
        for (int i = 1; i <= WARMUP + 8; i++) begin
            step(1'b0, base + 16'(i));
            if (i == WARMUP - 1) chk("ready_before_warm_end", ready, 0);
            if (i == WARMUP)     chk("ready_at_warm_end", ready, 1);
            if (i == WARMUP)     chk("valid_at_warm_end", rd_valid, 0);
            if (i == WARMUP + 1) chk("first_word", rd_data, base + 16'(WARMUP + 1));
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rd_req  = 1'b0;
        rand_in = 16'h1234;
        model_reset();
        rst = 1'b1;
        #1;
        check_zero("reset");
        step(1'b0, 16'h1111);
        step(1'b0, 16'h2222);
        rst = 1'b0;

        // Warm-up then idle until full (samples dropped)
        warmup_run(16'h0100);
        for (int i = 0; i < 50; i++) step(1'b0, 16'($urandom));
        chk("full_fill", fill_cnt, DEPTH);

        // Concurrent push/pop held at full
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 16'($urandom));
            chk("full_hold", fill_cnt, DEPTH);
        end

        // 5 pops / 3 idle across pointer wrap
        for (int i = 0; i < 100; i++) step((i % 8) < 5, 16'($urandom));

        // Random request pattern
        for (int i = 0; i < 60; i++) step(1'($urandom_range(0, 1)), 16'($urandom));

        // Reset mid-run with five words stored
        rst = 1'b1;
        step(1'b0, 16'h0);
        rst = 1'b0;
        for (int i = 0; i < WARMUP + 5; i++) step(1'b0, 16'($urandom));
        chk("fill_before_mid_reset", fill_cnt, 5);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        model_reset();
        step(1'b0, 16'h5555);
        rst = 1'b0;
        warmup_run(16'h4000);

        // Repetition-count health test
        for (int i = 0; i < 4; i++) step(1'b0, 16'hA5A5);
        for (int i = 0; i < 6; i++) step(1'($urandom_range(0, 1)), 16'($urandom));
`ifdef RAND_HEALTH_EN
        chk("health_set", health_fail, 1);
        chk("health_valid", rd_valid, 0);
        chk("health_fill", fill_cnt, 0);
        chk("health_ready", ready, 0);
`else
        chk("health_off", health_fail, 0);
        chk("health_off_ready", ready, 1);
`endif
        rst = 1'b1;
        #1;
        check_zero("final_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
